// File: rtl/half_subtractor_core.sv
// rtl/half_subtractor_core.sv - per-lane half subtractor with optional output register and borrow event counter
// Lanes are independent 1-bit cells; borrow_count tallies qualified cycles with any lane borrowing.
module half_subtractor_core #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned REGISTER_OUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr_count,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] borrow_c;
  logic             any_borrow;

  always_comb begin
    diff_c     = a ^ b;
    borrow_c   = ~a & b;
    any_borrow = |borrow_c;
  end

  logic [CNT_W-1:0] borrow_count_q;
  logic [CNT_W-1:0] borrow_count_d;

  // Clear wins over a same-edge increment; the counter parks at all-ones.
  always_comb begin
    borrow_count_d = borrow_count_q;
    if (clr_count) begin
      borrow_count_d = '0;
    end else if (in_valid && any_borrow && (borrow_count_q != CNT_MAX)) begin
      borrow_count_d = borrow_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_count_q <= '0;
    end else begin
      borrow_count_q <= borrow_count_d;
    end
  end

  assign borrow_count = borrow_count_q;

  generate
    if (REGISTER_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] diff_q;
      logic [WIDTH-1:0] diff_d;
      logic [WIDTH-1:0] borrow_q;
      logic [WIDTH-1:0] borrow_d;
      logic             out_valid_q;
      logic             out_valid_d;

      // Result registers only capture qualified inputs; out_valid tracks in_valid every edge.
      always_comb begin
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
          diff_d   = diff_c;
          borrow_d = borrow_c;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          diff_q      <= '0;
          borrow_q    <= '0;
          out_valid_q <= 1'b0;
        end else begin
          diff_q      <= diff_d;
          borrow_q    <= borrow_d;
          out_valid_q <= out_valid_d;
        end
      end

      assign diff      = diff_q;
      assign borrow    = borrow_q;
      assign out_valid = out_valid_q;
    end else begin : g_comb
      assign diff      = diff_c;
      assign borrow    = borrow_c;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_half_subtractor_core.sv
// tb/tb_half_subtractor_core.sv - bench for half_subtractor_core in combinational and registered builds
// Three instances share stimulus; an integer model predicts every output each cycle.
module tb_half_subtractor_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_valid = 1'b0;
  logic       clr_count = 1'b0;

  logic [0:0]  d0_diff, d0_borrow;
  logic        d0_ov;
  logic [15:0] d0_cnt;
  logic [3:0]  d1_diff, d1_borrow;
  logic        d1_ov;
  logic [1:0]  d1_cnt;
  logic [3:0]  d2_diff, d2_borrow;
  logic        d2_ov;
  logic [2:0]  d2_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  half_subtractor_core #(.WIDTH(1), .REGISTER_OUT(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .in_valid(in_valid),
    .clr_count(clr_count), .diff(d0_diff), .borrow(d0_borrow),
    .out_valid(d0_ov), .borrow_count(d0_cnt));

  half_subtractor_core #(.WIDTH(4), .REGISTER_OUT(1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .clr_count(clr_count), .diff(d1_diff), .borrow(d1_borrow),
    .out_valid(d1_ov), .borrow_count(d1_cnt));

  half_subtractor_core #(.WIDTH(4), .REGISTER_OUT(0), .CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .clr_count(clr_count), .diff(d2_diff), .borrow(d2_borrow),
    .out_valid(d2_ov), .borrow_count(d2_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic view of a half subtractor: difference is (x - y) mod 2, borrow is x < y.
  function automatic logic [3:0] m_diff(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (((int'(x[i]) - int'(y[i])) + 2) % 2) != 0;
    return r;
  endfunction

  function automatic logic [3:0] m_borrow(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = int'(x[i]) < int'(y[i]);
    return r;
  endfunction

  function automatic int next_cnt(input int c, input int maxv, input bit ev);
    if (clr_count) return 0;
    if (in_valid && ev && c < maxv) return c + 1;
    return c;
  endfunction

  logic [3:0] md1 = '0;
  logic [3:0] mb1 = '0;
  logic       mov1 = 1'b0;
  int         mc0 = 0;
  int         mc1 = 0;
  int         mc2 = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] bw;
    bw = m_borrow(a, b);
    if (!rst_n) begin
      md1 <= '0; mb1 <= '0; mov1 <= 1'b0;
      mc0 <= 0; mc1 <= 0; mc2 <= 0;
    end else begin
      if (in_valid) begin
        md1 <= m_diff(a, b);
        mb1 <= bw;
      end
      mov1 <= in_valid;
      mc0 <= next_cnt(mc0, 65535, bw[0]);
      mc1 <= next_cnt(mc1, 3, bw != 0);
      mc2 <= next_cnt(mc2, 7, bw != 0);
    end
  end

  always @(negedge clk) begin
    logic [3:0] ed, eb;
    if (check_en) begin
      ed = m_diff(a, b);
      eb = m_borrow(a, b);
      chk("d0_diff", 32'(d0_diff), 32'(ed[0]));
      chk("d0_borrow", 32'(d0_borrow), 32'(eb[0]));
      chk("d0_ov", 32'(d0_ov), 32'(in_valid));
      chk("d0_cnt", 32'(d0_cnt), 32'(mc0));
      chk("d2_diff", 32'(d2_diff), 32'(ed));
      chk("d2_borrow", 32'(d2_borrow), 32'(eb));
      chk("d2_ov", 32'(d2_ov), 32'(in_valid));
      chk("d2_cnt", 32'(d2_cnt), 32'(mc2));
      chk("d1_diff", 32'(d1_diff), 32'(md1));
      chk("d1_borrow", 32'(d1_borrow), 32'(mb1));
      chk("d1_ov", 32'(d1_ov), 32'(mov1));
      chk("d1_cnt", 32'(d1_cnt), 32'(mc1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] v1 [4];
    logic [1:0] e1 [4];
    logic [1:0] e5 [5];
    logic [3:0] va [4];
    logic [3:0] vb [4];
    v1 = '{2'b00, 2'b01, 2'b10, 2'b11};
    e1 = '{2'b00, 2'b11, 2'b10, 2'b00};
    e5 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    va = '{4'b1001, 4'b0110, 4'b1111, 4'b0000};
    vb = '{4'b0011, 4'b1100, 4'b1010, 4'b0101};

    #2 rst_n = 1'b0;
    step();
    step();
    chk("reset_d1_diff", 32'(d1_diff), 32'h0);
    chk("reset_d1_borrow", 32'(d1_borrow), 32'h0);
    chk("reset_d1_ov", 32'(d1_ov), 32'h0);
    chk("reset_d1_cnt", 32'(d1_cnt), 32'h0);
    chk("reset_d0_cnt", 32'(d0_cnt), 32'h0);
    rst_n = 1'b1;
    check_en = 1'b1;
    step();

    // Truth table on the single-lane combinational build, each vector held 100 ns.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = {3'b000, v1[k][1]};
      b = {3'b000, v1[k][0]};
      #1;
      chk("tt_diff_borrow", {30'h0, d0_diff, d0_borrow}, 32'(e1[k]));
      for (int c = 0; c < 10; c++) step();
    end
    chk("tt_d0_cnt", 32'(d0_cnt), 32'd10);

    // Registered build: result appears only after the loading edge.
    in_valid = 1'b0; a = '0; b = '0;
    step();
    a = 4'b0001; b = 4'b0000; in_valid = 1'b1;
    #1;
    chk("lat_before_ov", 32'(d1_ov), 32'h0);
    chk("lat_before_diff", 32'(d1_diff), 32'h0);
    step();
    chk("lat_after_ov", 32'(d1_ov), 32'h1);
    chk("lat_after_diff", 32'(d1_diff), 32'h1);
    chk("lat_after_borrow", 32'(d1_borrow), 32'h0);

    a = 4'b0101; b = 4'b0011;
    #1;
    chk("w4_comb_diff", 32'(d2_diff), 32'h6);
    chk("w4_comb_borrow", 32'(d2_borrow), 32'h2);
    step();
    chk("w4_reg_diff", 32'(d1_diff), 32'h6);
    chk("w4_reg_borrow", 32'(d1_borrow), 32'h2);

    // Asynchronous reset between edges clears immediately and blocks the next edge.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_diff", 32'(d1_diff), 32'h0);
    chk("arst_borrow", 32'(d1_borrow), 32'h0);
    chk("arst_ov", 32'(d1_ov), 32'h0);
    chk("arst_cnt1", 32'(d1_cnt), 32'h0);
    chk("arst_cnt0", 32'(d0_cnt), 32'h0);
    step();
    chk("arst_hold_diff", 32'(d1_diff), 32'h0);
    rst_n = 1'b1;
    step();
    chk("arst_reload_diff", 32'(d1_diff), 32'h6);

    // Saturation of the 2-bit counter, then clear beats a simultaneous increment.
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    a = 4'b0000; b = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("sat_cnt", 32'(d1_cnt), 32'(e5[k]));
    end
    clr_count = 1'b1;
    step();
    chk("clr_pri_cnt1", 32'(d1_cnt), 32'h0);
    chk("clr_pri_cnt2", 32'(d2_cnt), 32'h0);
    clr_count = 1'b0;

    // With in_valid low the registered results and counter hold.
    a = 4'b0101; b = 4'b0011;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = va[k]; b = vb[k];
      step();
      chk("hold_diff", 32'(d1_diff), 32'h6);
      chk("hold_borrow", 32'(d1_borrow), 32'h2);
      chk("hold_ov", 32'(d1_ov), 32'h0);
      chk("hold_cnt", 32'(d1_cnt), 32'h1);
    end

    // Mixed traffic under model checking only.
    for (int k = 0; k < 40; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      in_valid = 1'($urandom_range(0, 1));
      clr_count = ($urandom_range(0, 9) == 0);
      step();
    end
    clr_count = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
